// File: rtl/oreg_stream_buffer.sv
// Multi-channel sample FIFO with registered first-word-fall-through head, sample/drop counters
// and runtime backpressure / overwrite-oldest mode.
module oreg_stream_buffer #(
  parameter int unsigned N_CH   = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [N_CH*DATA_W-1:0]       s_data,
  input  logic                         mode,
  input  logic                         clear,
  input  logic                         rd_pop,
  output logic [N_CH*DATA_W-1:0]       oreg_data,
  output logic                         oreg_valid,
  output logic [$clog2(DEPTH+1)-1:0]   oreg_level,
  output logic [CNT_W-1:0]             oreg_count,
  output logic [CNT_W-1:0]             oreg_drop
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam int unsigned VW = N_CH * DATA_W;

  logic [VW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [VW-1:0]    head_q, head_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] count_q, count_d, drop_q, drop_d;

  logic full, empty, accept, pop, drop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign s_ready = !clear && (mode || !full);
  assign accept  = s_valid && s_ready;
  assign pop     = rd_pop && valid_q && !clear;
  // Overwrite-oldest: accepting into a full buffer without a pop discards the head.
  assign drop    = accept && full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    valid_d  = valid_q;
    head_d   = head_q;
    count_d  = count_q + CNT_W'(accept);
    drop_d   = drop_q + CNT_W'(drop);
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      valid_d  = 1'b0;
    end else begin
      if (accept) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop || drop) rd_ptr_d = rd_ptr_q + AW'(1);
      if (accept && !pop && !full) begin
        level_d = level_q + LW'(1);
      end else if (pop && !accept) begin
        level_d = level_q - LW'(1);
      end
      valid_d = (level_d != '0);
      // Head reloads only when it moves or the buffer was empty; the new head may be the
      // beat being written this cycle, which is not yet in mem.
      if ((pop || drop || (accept && empty)) && (level_d != '0)) begin
        head_d = (accept && (wr_ptr_q == rd_ptr_d)) ? s_data : mem[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr_q] <= s_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      valid_q  <= 1'b0;
      head_q   <= '0;
      count_q  <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      valid_q  <= valid_d;
      head_q   <= head_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  end

  assign oreg_data  = head_q;
  assign oreg_valid = valid_q;
  assign oreg_level = level_q;
  assign oreg_count = count_q;
  assign oreg_drop  = drop_q;

endmodule

// File: tb/tb_oreg_stream_buffer.sv
// Directed bench for oreg_stream_buffer: vector table for basic FIFO flow plus hand sequences
// for fill, overwrite, clear, async reset and a narrow-counter wrap instance.
module tb_oreg_stream_buffer;

  localparam int N_CH = 8;
  localparam int DW   = 32;
  localparam int VW   = N_CH * DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_valid, mode, clear, rd_pop;
  logic [VW-1:0] s_data;
  logic          s_ready, oreg_valid;
  logic [VW-1:0] oreg_data;
  logic [4:0]    oreg_level;
  logic [31:0]   oreg_count, oreg_drop;
  logic          s_ready4, oreg_valid4;
  logic [VW-1:0] oreg_data4;
  logic [4:0]    oreg_level4;
  logic [3:0]    oreg_count4, oreg_drop4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  oreg_stream_buffer #(.N_CH(N_CH), .DATA_W(DW), .DEPTH(16), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .mode(mode), .clear(clear), .rd_pop(rd_pop), .oreg_data(oreg_data),
    .oreg_valid(oreg_valid), .oreg_level(oreg_level), .oreg_count(oreg_count),
    .oreg_drop(oreg_drop)
  );

  oreg_stream_buffer #(.N_CH(N_CH), .DATA_W(DW), .DEPTH(16), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready4), .s_data(s_data),
    .mode(mode), .clear(clear), .rd_pop(rd_pop), .oreg_data(oreg_data4),
    .oreg_valid(oreg_valid4), .oreg_level(oreg_level4), .oreg_count(oreg_count4),
    .oreg_drop(oreg_drop4)
  );

  typedef struct {
    logic        v, m, c, p;
    int          n;
    logic        e_rdy, e_vld;
    logic [31:0] e_ch0;
    int          e_lvl, e_cnt, e_drp;
  } vec_t;

  vec_t tbl [9];

  function automatic logic [VW-1:0] mk(input int n);
    logic [VW-1:0] r;
    for (int k = 0; k < N_CH; k++) r[k*DW +: DW] = 32'(32'h100 * n + k);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic m, input logic c, input logic p,
                       input int n);
    s_valid = v; mode = m; clear = c; rd_pop = p; s_data = mk(n);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string nm, input int lvl, input int cnt, input int drp);
    chk({nm, "_level"}, 64'(oreg_level), 64'(lvl));
    chk({nm, "_count"}, 64'(oreg_count), 64'(cnt));
    chk({nm, "_drop"},  64'(oreg_drop),  64'(drp));
  endtask

  initial begin
    //          v  m  c  p  n   rdy vld ch0     lvl cnt drp
    tbl[0] = '{1, 0, 0, 0, 0,  1,  1,  32'h000, 1,  1,  0};
    tbl[1] = '{1, 0, 0, 0, 1,  1,  1,  32'h000, 2,  2,  0};
    tbl[2] = '{1, 0, 0, 0, 2,  1,  1,  32'h000, 3,  3,  0};
    tbl[3] = '{0, 0, 0, 1, 0,  1,  1,  32'h100, 2,  3,  0};
    tbl[4] = '{0, 0, 0, 1, 0,  1,  1,  32'h200, 1,  3,  0};
    tbl[5] = '{0, 0, 0, 1, 0,  1,  0,  32'h000, 0,  3,  0};
    tbl[6] = '{0, 0, 0, 1, 0,  1,  0,  32'h000, 0,  3,  0};
    tbl[7] = '{1, 0, 0, 1, 3,  1,  1,  32'h300, 1,  4,  0};
    tbl[8] = '{0, 0, 0, 1, 0,  1,  0,  32'h000, 0,  4,  0};

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    #12;
    chk("rst_ready", 64'(s_ready), 64'd1);
    chk("rst_valid", 64'(oreg_valid), 64'd0);
    chk("rst_data", 64'(oreg_data == '0), 64'd1);
    chk_state("rst", 0, 0, 0);
    #5 rst_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].v, tbl[i].m, tbl[i].c, tbl[i].p, tbl[i].n);
      #1;
      chk($sformatf("vec%0d_ready", i), 64'(s_ready), 64'(tbl[i].e_rdy));
      tick();
      chk($sformatf("vec%0d_valid", i), 64'(oreg_valid), 64'(tbl[i].e_vld));
      if (tbl[i].e_vld) chk($sformatf("vec%0d_ch0", i), 64'(oreg_data[31:0]), 64'(tbl[i].e_ch0));
      chk_state($sformatf("vec%0d", i), tbl[i].e_lvl, tbl[i].e_cnt, tbl[i].e_drp);
    end

    // Backpressure fill: 20 beats offered, only 16 fit.
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 0, 0, 10 + i);
      #1;
      chk($sformatf("fill%0d_ready", i), 64'(s_ready), 64'(i < 16));
      tick();
    end
    chk_state("fill", 16, 20, 0);
    chk("fill_ch0", 64'(oreg_data[31:0]), 64'h0A00);
    chk("fill_ch7", 64'(oreg_data[7*DW +: DW]), 64'h0A07);
    drive(1, 0, 0, 1, 30);
    #1;
    chk("full_pop_ready", 64'(s_ready), 64'd0);
    tick();
    chk_state("full_pop", 15, 20, 0);
    chk("full_pop_ch0", 64'(oreg_data[31:0]), 64'h0B00);
    drive(1, 0, 0, 0, 30);
    #1;
    chk("refill_ready", 64'(s_ready), 64'd1);
    tick();
    chk_state("refill", 16, 21, 0);
    drive(0, 0, 1, 0, 0);
    tick();
    chk_state("clr1", 0, 21, 0);
    chk("clr1_valid", 64'(oreg_valid), 64'd0);

    // Overwrite mode: 20 pushes, 4 oldest discarded.
    for (int i = 0; i < 20; i++) begin
      drive(1, 1, 0, 0, i);
      #1;
      chk($sformatf("ovw%0d_ready", i), 64'(s_ready), 64'd1);
      tick();
    end
    chk_state("ovw", 16, 41, 4);
    chk("ovw_ch0", 64'(oreg_data[31:0]), 64'h0400);
    drive(1, 1, 0, 1, 20);
    tick();
    chk_state("ovw_pp", 16, 42, 4);
    chk("ovw_pp_ch0", 64'(oreg_data[31:0]), 64'h0500);
    drive(1, 0, 0, 0, 21);
    #1;
    chk("mode_sw_ready", 64'(s_ready), 64'd0);
    tick();
    chk_state("mode_sw", 16, 42, 4);
    for (int i = 0; i < 11; i++) begin
      drive(0, 0, 0, 1, 0);
      tick();
    end
    chk("drain_level", 64'(oreg_level), 64'd5);
    chk("drain_ch0", 64'(oreg_data[31:0]), 64'h1000);
    drive(1, 0, 1, 1, 22);
    #1;
    chk("clr2_ready", 64'(s_ready), 64'd0);
    tick();
    chk_state("clr2", 0, 42, 4);
    chk("clr2_valid", 64'(oreg_valid), 64'd0);

    // Async reset mid-stream.
    for (int i = 0; i < 7; i++) begin
      drive(1, 0, 0, 0, 50 + i);
      tick();
    end
    drive(0, 0, 0, 0, 0);
    chk_state("pre_rst", 7, 49, 4);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(oreg_valid), 64'd0);
    chk("arst_data", 64'(oreg_data == '0), 64'd1);
    chk_state("arst", 0, 0, 0);
    #2 rst_n = 1'b1;
    tick();
    chk("post_rst_ready", 64'(s_ready), 64'd1);

    // Narrow counter wraps 15 -> 0 on the 16th accept.
    for (int i = 0; i < 16; i++) begin
      drive(1, 1, 0, 0, i);
      tick();
      if (i == 14) chk("wrap_cnt15", 64'(oreg_count4), 64'd15);
    end
    chk("wrap_cnt0", 64'(oreg_count4), 64'd0);
    chk("wrap_cnt_wide", 64'(oreg_count), 64'd16);
    drive(0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
